// File: rtl/spatz_issue_if.sv
// spatz_issue_if: decoded-request, dispatch and completion signals between decoder/units and the issue scheduler
interface spatz_issue_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_illegal;
    logic [1:0]  req_ex_unit;
    logic [4:0]  req_vd;
    logic        req_use_vd;
    logic        req_vd_is_src;
    logic [4:0]  req_vs1;
    logic        req_use_vs1;
    logic [4:0]  req_vs2;
    logic        req_use_vs2;
    logic [2:0]  unit_valid;
    logic [2:0]  unit_ready;
    logic [4:0]  unit_vd;
    logic [2:0]  unit_done;
    logic [14:0] unit_done_vd;
    logic        illegal;
    logic        busy;
    modport master (
        output req_valid, req_illegal, req_ex_unit, req_vd, req_use_vd, req_vd_is_src,
               req_vs1, req_use_vs1, req_vs2, req_use_vs2, unit_ready, unit_done, unit_done_vd,
        input  req_ready, unit_valid, unit_vd, illegal, busy
    );
    modport slave (
        input  req_valid, req_illegal, req_ex_unit, req_vd, req_use_vd, req_vd_is_src,
               req_vs1, req_use_vs1, req_vs2, req_use_vs2, unit_ready, unit_done, unit_done_vd,
        output req_ready, unit_valid, unit_vd, illegal, busy
    );
endinterface

// File: rtl/spatz_issue_scheduler.sv
// spatz_issue_scheduler: holds one decoded request, checks it against a per-vreg busy scoreboard and
// per-unit outstanding counters, and dispatches in order to CON/VFU/LSU
module spatz_issue_scheduler #(
    parameter int NrVRegs        = 32,
    parameter int MaxOutstanding = 4
) (
    input logic        clk_i,
    input logic        rst_i,
    spatz_issue_if.slave p
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WAIT  = 2'd1;
    localparam logic [1:0] ISSUE = 2'd2;
    logic [1:0]         state;
    logic [1:0]         unit;
    logic [4:0]         vd, vs1, vs2;
    logic               use_vd, vd_src, use_vs1, use_vs2;
    logic [NrVRegs-1:0] sb, sb_n;
    logic [3:0]         cnt [3];
    logic [3:0]         cnt_n [3];
    logic [2:0]         done_ok;
    logic               illegal_q, hazard, issue, fire, accept, drop;
    // Hazards only ever clear while a request is held, so a raised valid never has to drop.
    assign hazard = (use_vs1 & sb[vs1]) | (use_vs2 & sb[vs2]) | ((vd_src | use_vd) & sb[vd])
                  | (cnt[unit] == 4'(MaxOutstanding));
    assign issue        = (state == ISSUE) | ((state == WAIT) & ~hazard);
    assign p.unit_valid = issue ? (3'b001 << unit) : 3'b000;
    assign p.unit_vd    = vd;
    assign fire         = |(p.unit_valid & p.unit_ready);
    assign p.req_ready  = (state == IDLE) | fire;
    assign accept       = p.req_valid & p.req_ready;
    assign drop         = p.req_illegal | (&p.req_ex_unit);
    assign p.illegal    = illegal_q;
    assign p.busy       = (state != IDLE) | (|sb) | (cnt[0] != '0) | (cnt[1] != '0) | (cnt[2] != '0);
    always_comb begin
        sb_n = sb;
        for (int u = 0; u < 3; u++) begin
            done_ok[u] = p.unit_done[u] && cnt[u] != '0;
            if (done_ok[u]) sb_n[p.unit_done_vd[u*5 +: 5]] = 1'b0;
            cnt_n[u] = cnt[u] + 4'(fire && unit == 2'(u)) - 4'(done_ok[u]);
        end
        if (fire && use_vd) sb_n[vd] = 1'b1;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            sb        <= '0;
            illegal_q <= 1'b0;
            for (int u = 0; u < 3; u++) cnt[u] <= '0;
        end else begin
            state     <= (accept & ~drop) ? WAIT : fire ? IDLE : issue ? ISSUE : state;
            sb        <= sb_n;
            illegal_q <= accept & drop;
            for (int u = 0; u < 3; u++) cnt[u] <= cnt_n[u];
        end
    end
    always_ff @(posedge clk_i) begin
        if (accept & ~drop) begin
            unit    <= p.req_ex_unit;
            vd      <= p.req_vd;
            use_vd  <= p.req_use_vd;
            vd_src  <= p.req_vd_is_src;
            vs1     <= p.req_vs1;
            use_vs1 <= p.req_use_vs1;
            vs2     <= p.req_vs2;
            use_vs2 <= p.req_use_vs2;
        end
    end
    for (genvar g = 0; g < 3; g++) begin : g_chk
        assert property (@(posedge clk_i) disable iff (rst_i) !(p.unit_done[g] && cnt[g] == '0));
        assert property (@(posedge clk_i) disable iff (rst_i)
            !(fire && use_vd && done_ok[g] && p.unit_done_vd[g*5 +: 5] == vd));
    end
endmodule

// File: tb/tb_spatz_issue_scheduler.sv
// tb_spatz_issue_scheduler: directed vector tables plus randomized traffic against a queue-based model
module tb_spatz_issue_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spatz_issue_if bus();
    spatz_issue_scheduler #(.NrVRegs(32), .MaxOutstanding(4)) dut (.clk_i(clk), .rst_i(rst), .p(bus));

    typedef struct {
        logic        rv, ill;
        logic [1:0]  eu;
        logic [4:0]  vd;
        logic        uvd, vsrc;
        logic [4:0]  vs1;
        logic        u1;
        logic [4:0]  vs2;
        logic        u2;
        logic [2:0]  rdy, dn;
        logic [14:0] dvd;
        logic        e_rdy;
        logic [2:0]  e_val;
        logic [4:0]  e_vd;
        logic        e_ill, e_busy;
    } vec_t;

    typedef struct packed { logic [1:0] u; logic [4:0] vd; } fl_t;

    int checks = 0;
    int errors = 0;

    vec_t tbl [21];
    vec_t cap [15];
    vec_t rsq [8];

    logic        mhv, mill;
    vec_t        mh;
    logic [31:0] mbusy;
    fl_t         fl [$];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic step(input vec_t v, input logic r, input string tag);
        rst                  = r;
        bus.req_valid        = v.rv;
        bus.req_illegal      = v.ill;
        bus.req_ex_unit      = v.eu;
        bus.req_vd           = v.vd;
        bus.req_use_vd       = v.uvd;
        bus.req_vd_is_src    = v.vsrc;
        bus.req_vs1          = v.vs1;
        bus.req_use_vs1      = v.u1;
        bus.req_vs2          = v.vs2;
        bus.req_use_vs2      = v.u2;
        bus.unit_ready       = v.rdy;
        bus.unit_done        = v.dn;
        bus.unit_done_vd     = v.dvd;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(v.e_rdy));
        chk({tag, ".unit_valid"}, 32'(bus.unit_valid), 32'(v.e_val));
        if (v.e_val != 3'b000) chk({tag, ".unit_vd"}, 32'(bus.unit_vd), 32'(v.e_vd));
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(v.e_ill));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(v.e_busy));
        @(posedge clk);
        #1;
    endtask

    function automatic int cnt_of(input logic [1:0] u);
        int n = 0;
        foreach (fl[i]) if (fl[i].u == u) n++;
        return n;
    endfunction

    function automatic int first_of(input int u);
        foreach (fl[i]) if (32'(fl[i].u) == u) return i;
        return -1;
    endfunction

    function automatic logic haz_of(input vec_t h);
        return (h.u1 && mbusy[h.vs1]) || (h.u2 && mbusy[h.vs2]) || ((h.vsrc || h.uvd) && mbusy[h.vd])
            || cnt_of(h.eu) == 4;
    endfunction

    initial begin
        // rv ill eu vd uvd vsrc vs1 u1 vs2 u2 rdy dn dvd | e_rdy e_val e_vd e_ill e_busy
        tbl[0]  = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,0};
        tbl[1]  = '{1,0,1,3,1,0,1,1,2,1,3'b010,3'b000,0,     1,3'b000,0,0,0};
        tbl[2]  = '{0,0,0,0,0,0,0,0,0,0,3'b010,3'b000,0,     1,3'b010,3,0,1};
        tbl[3]  = '{1,0,1,4,1,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,1};
        tbl[4]  = '{1,0,2,0,0,0,0,0,4,1,3'b010,3'b000,0,     1,3'b010,4,0,1};
        tbl[5]  = '{0,0,0,0,0,0,0,0,0,0,3'b100,3'b000,0,     0,3'b000,0,0,1};
        tbl[6]  = '{0,0,0,0,0,0,0,0,0,0,3'b100,3'b010,128,   0,3'b000,0,0,1};
        tbl[7]  = '{0,0,0,0,0,0,0,0,0,0,3'b100,3'b000,0,     1,3'b100,0,0,1};
        tbl[8]  = '{1,1,0,9,1,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,1};
        tbl[9]  = '{1,0,3,10,1,0,0,0,0,0,3'b000,3'b000,0,    1,3'b000,0,1,1};
        tbl[10] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,1,1};
        tbl[11] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b110,96,    1,3'b000,0,0,1};
        tbl[12] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,0};
        tbl[13] = '{1,0,0,0,0,0,0,0,0,0,3'b001,3'b000,0,     1,3'b000,0,0,0};
        tbl[14] = '{1,0,0,0,0,0,0,0,0,0,3'b001,3'b000,0,     1,3'b001,0,0,1};
        tbl[15] = '{1,0,0,0,0,0,0,0,0,0,3'b001,3'b000,0,     1,3'b001,0,0,1};
        tbl[16] = '{0,0,0,0,0,0,0,0,0,0,3'b001,3'b000,0,     1,3'b001,0,0,1};
        tbl[17] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b001,0,     1,3'b000,0,0,1};
        tbl[18] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b001,0,     1,3'b000,0,0,1};
        tbl[19] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b001,0,     1,3'b000,0,0,1};
        tbl[20] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,0};

        cap[0]  = '{1,0,0,0,0,0,0,0,0,0,3'b111,3'b000,0,     1,3'b000,0,0,0};
        cap[1]  = '{1,0,2,20,1,0,0,0,0,0,3'b111,3'b000,0,    1,3'b001,0,0,1};
        cap[2]  = '{1,0,1,10,1,0,0,0,0,0,3'b111,3'b000,0,    1,3'b100,20,0,1};
        cap[3]  = '{1,0,1,11,1,0,0,0,0,0,3'b111,3'b000,0,    1,3'b010,10,0,1};
        cap[4]  = '{1,0,1,12,1,0,0,0,0,0,3'b111,3'b000,0,    1,3'b010,11,0,1};
        cap[5]  = '{1,0,1,13,1,0,0,0,0,0,3'b111,3'b000,0,    1,3'b010,12,0,1};
        cap[6]  = '{1,0,1,14,1,0,0,0,0,0,3'b111,3'b000,0,    1,3'b010,13,0,1};
        cap[7]  = '{0,0,0,0,0,0,0,0,0,0,3'b111,3'b000,0,     0,3'b000,0,0,1};
        cap[8]  = '{0,0,0,0,0,0,0,0,0,0,3'b111,3'b010,320,   0,3'b000,0,0,1};
        cap[9]  = '{0,0,0,0,0,0,0,0,0,0,3'b111,3'b000,0,     1,3'b010,14,0,1};
        cap[10] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b111,20832, 1,3'b000,0,0,1};
        cap[11] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b010,384,   1,3'b000,0,0,1};
        cap[12] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b010,416,   1,3'b000,0,0,1};
        cap[13] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b010,448,   1,3'b000,0,0,1};
        cap[14] = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,0};

        rsq[0]  = '{1,0,1,7,1,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,0};
        rsq[1]  = '{1,0,2,8,1,0,0,0,0,0,3'b010,3'b000,0,     1,3'b010,7,0,1};
        rsq[2]  = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     0,3'b100,8,0,1};
        rsq[3]  = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,0};
        rsq[4]  = '{1,0,1,9,1,0,7,1,0,0,3'b010,3'b000,0,     1,3'b000,0,0,0};
        rsq[5]  = '{0,0,0,0,0,0,0,0,0,0,3'b010,3'b000,0,     1,3'b010,9,0,1};
        rsq[6]  = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b010,288,   1,3'b000,0,0,1};
        rsq[7]  = '{0,0,0,0,0,0,0,0,0,0,3'b000,3'b000,0,     1,3'b000,0,0,0};

        step(tbl[0], 1'b1, "pre");
        checks = 0;
        errors = 0;
        step(tbl[0], 1'b1, "pre");
        checks = 0;
        errors = 0;
        for (int i = 0; i < 21; i++) step(tbl[i], 1'b0, $sformatf("tbl%0d", i));
        for (int i = 0; i < 15; i++) step(cap[i], 1'b0, $sformatf("cap%0d", i));
        // Reset lands while the LSU request is being offered and busy[7] is set.
        for (int i = 0; i < 8; i++) step(rsq[i], i == 2, $sformatf("rst%0d", i));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mhv   = 1'b0;
        mill  = 1'b0;
        mbusy = '0;
        fl.delete();
        for (int c = 0; c < 3000; c++) begin
            vec_t v;
            logic haz, fire, acc, bad;
            int idx;
            v = tbl[0];
            v.rv   = ($urandom % 10) < 7;
            v.ill  = ($urandom % 16) == 0;
            v.eu   = 2'($urandom_range(0, 3));
            v.vd   = 5'($urandom_range(0, 7));
            v.uvd  = 1'b1;
            v.vsrc = 1'($urandom);
            v.vs1  = 5'($urandom_range(0, 7));
            v.u1   = 1'($urandom);
            v.vs2  = 5'($urandom_range(0, 7));
            v.u2   = 1'($urandom);
            v.rdy  = 3'($urandom);
            for (int u = 0; u < 3; u++) begin
                idx = first_of(u);
                if (idx >= 0 && ($urandom % 3) == 0) begin
                    v.dn[u]          = 1'b1;
                    v.dvd[u*5 +: 5]  = fl[idx].vd;
                end
            end
            haz      = mhv && haz_of(mh);
            v.e_val  = (mhv && !haz) ? (3'b001 << mh.eu) : 3'b000;
            v.e_vd   = mh.vd;
            fire     = |(v.e_val & v.rdy);
            v.e_rdy  = !mhv || fire;
            v.e_ill  = mill;
            v.e_busy = mhv || (mbusy != 0) || fl.size() != 0;
            step(v, 1'b0, "rnd");
            acc  = v.rv && v.e_rdy;
            bad  = v.ill || v.eu == 2'd3;
            mill = acc && bad;
            for (int u = 0; u < 3; u++) begin
                if (v.dn[u]) begin
                    idx = first_of(u);
                    mbusy[fl[idx].vd] = 1'b0;
                    fl.delete(idx);
                end
            end
            if (fire) begin
                if (mh.uvd) mbusy[mh.vd] = 1'b1;
                fl.push_back('{mh.eu, mh.vd});
                mhv = 1'b0;
            end
            if (acc && !bad) begin
                mhv = 1'b1;
                mh  = v;
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
